// File: rtl/lb_pkg.sv
// +-----------------------------------------------------------------------------
// | lb_pkg: shared encodings and widths for the line-buffer controllers
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package lb_pkg;

  localparam int CNT_W = 11;
  localparam int K_DEF = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FILL = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/lb_pos_counter.sv
// +-----------------------------------------------------------------------------
// | lb_pos_counter: raster column/row position tracker with wrap and fill compare
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module lb_pos_counter #(
  parameter int CNT_W    = 11,
  parameter int FILL_ROW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] cols,
  input  logic [CNT_W-1:0] rows,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             last_col,
  output logic             last_row,
  output logic             fill_done
);

  assign last_col  = (col == cols - CNT_W'(1));
  assign last_row  = (row == rows - CNT_W'(1));
  // Last pixel of the priming rows: the taps are full from the next row on
  assign fill_done = last_col && (row == CNT_W'(FILL_ROW));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + CNT_W'(1);
      end else begin
        col <= col + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/linebuf_window_ctrl.sv
// +-----------------------------------------------------------------------------
// | linebuf_window_ctrl: frame sequencer and KxK window qualifier for the line buffer
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module linebuf_window_ctrl
  import lb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_COLS = 482,
  parameter int MAX_ROWS = 256,
  parameter int K        = K_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_cols,
  input  logic [CNT_W-1:0] cfg_rows,
  input  logic             cfg_stride2,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             lb_valid_in,
  output logic [WIDTH-1:0] lb_din,
  input  logic             win_ready,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  state_t           state;
  logic [CNT_W-1:0] cols_q;
  logic [CNT_W-1:0] rows_q;
  logic             stride2_q;

  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic             last_col;
  logic             last_row;
  logic             fill_done;

  logic             accept;
  logic             cfg_legal;
  logic             clr_cnt;
  logic [CNT_W-1:0] dr;
  logic [CNT_W-1:0] dc;
  logic             win_hit;

  always_comb begin
    s_ready = 1'b0;
    case (state)
      ST_FILL: s_ready = 1'b1;
      ST_RUN:  s_ready = win_ready;
      default: s_ready = 1'b0;
    endcase
  end

  assign accept      = s_valid & s_ready;
  assign lb_valid_in = accept;
  assign lb_din      = s_data;

  assign cfg_legal = (cfg_cols >= CNT_W'(K)) && (cfg_cols <= CNT_W'(MAX_COLS)) &&
                     (cfg_rows >= CNT_W'(K)) && (cfg_rows <= CNT_W'(MAX_ROWS));
  assign clr_cnt   = (state == ST_IDLE) && start && cfg_legal;

  lb_pos_counter #(
    .CNT_W    (CNT_W),
    .FILL_ROW (K - 2)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr_cnt),
    .adv       (accept),
    .cols      (cols_q),
    .rows      (rows_q),
    .col       (col),
    .row       (row),
    .last_col  (last_col),
    .last_row  (last_row),
    .fill_done (fill_done)
  );

  // Offsets of the accepted pixel from the first complete window position
  assign dr = row - CNT_W'(K - 1);
  assign dc = col - CNT_W'(K - 1);

  assign win_hit = accept && (row >= CNT_W'(K - 1)) && (col >= CNT_W'(K - 1)) &&
                   (!stride2_q || (!dr[0] && !dc[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cols_q     <= '0;
      rows_q     <= '0;
      stride2_q  <= 1'b0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err    <= 1'b0;
      frame_done <= 1'b0;
      win_valid  <= win_hit;
      // Coordinates hold between windows so the PE array can re-read them
      if (win_hit) begin
        win_row <= dr >> stride2_q;
        win_col <= dc >> stride2_q;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              cols_q    <= cfg_cols;
              rows_q    <= cfg_rows;
              stride2_q <= cfg_stride2;
              busy      <= 1'b1;
              state     <= ST_FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (accept && fill_done) state <= ST_RUN;
        end
        ST_RUN: begin
          if (accept && last_col && last_row) begin
            frame_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linebuf_window_ctrl.sv
// Directed bench for linebuf_window_ctrl: frame sequencing, window tagging, stall and
// configuration rejection, with expected windows derived from output-map coordinates.
`default_nettype none

module tb_linebuf_window_ctrl;

  localparam int KK   = 3;
  localparam int MAXC = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] cfg_cols;
  logic [10:0] cfg_rows;
  logic        cfg_stride2;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        lb_valid_in;
  logic [7:0]  lb_din;
  logic        win_ready;
  logic        win_valid;
  logic [10:0] win_row;
  logic [10:0] win_col;
  logic        busy;
  logic        frame_done;
  logic        cfg_err;

  int checks   = 0;
  int failures = 0;

  int n_acc, n_win, n_done, done_prev_pix, cfg_err_seen, stall_cycles, stall_viol, din_err;
  bit timed_out;
  int win_r[$];
  int win_c[$];
  int win_p[$];

  always #5 clk = ~clk;

  linebuf_window_ctrl #(
    .WIDTH    (8),
    .MAX_COLS (482),
    .MAX_ROWS (256),
    .K        (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_cols    (cfg_cols),
    .cfg_rows    (cfg_rows),
    .cfg_stride2 (cfg_stride2),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .lb_valid_in (lb_valid_in),
    .lb_din      (lb_din),
    .win_ready   (win_ready),
    .win_valid   (win_valid),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  // Raster index of the pixel that completes output-map window (wr, wc)
  function automatic int exp_pix(input int cols, input int s2, input int wr, input int wc);
    return ((wr << s2) + KK - 1) * cols + (wc << s2) + KK - 1;
  endfunction

  // Drives one frame from a start pulse until frame_done, recording what it observes
  task automatic run_frame(input int cols, input int rows, input bit s2,
                           input int stall_len, input int poke_cycle);
    int cyc, prev_pix, cur, stall_left;
    bit done, in_stall;
    n_acc = 0; n_win = 0; n_done = 0; done_prev_pix = -2; cfg_err_seen = 0;
    stall_cycles = 0; stall_viol = 0; din_err = 0;
    win_r.delete(); win_c.delete(); win_p.delete();
    cfg_cols = 11'(cols); cfg_rows = 11'(rows); cfg_stride2 = s2;
    start = 1'b1; s_valid = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; prev_pix = -1; stall_left = 0; done = 1'b0;
    while (!done && cyc < MAXC) begin
      in_stall = (stall_left > 0);
      if (in_stall) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = 1'b1;
      end
      if (win_valid === 1'b1) begin
        win_r.push_back(int'(win_row));
        win_c.push_back(int'(win_col));
        win_p.push_back(prev_pix);
        n_win++;
        if (n_win == 1) stall_left = stall_len;
      end
      if (frame_done === 1'b1) begin
        n_done++;
        done_prev_pix = prev_pix;
        done = 1'b1;
      end
      if (cfg_err === 1'b1) cfg_err_seen++;
      if (cyc == poke_cycle) begin
        start = 1'b1; cfg_cols = 11'd3;
      end else begin
        start = 1'b0; cfg_cols = 11'(cols);
      end
      s_data = 8'($urandom);
      #1;
      if (lb_din !== s_data) din_err++;
      cur = -1;
      if (lb_valid_in === 1'b1) begin
        cur = n_acc;
        n_acc++;
      end
      if (in_stall) begin
        stall_cycles++;
        if (s_ready !== 1'b0 || lb_valid_in !== 1'b0) stall_viol++;
      end
      prev_pix = cur;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; cfg_cols = 11'(cols); win_ready = 1'b1; s_valid = 1'b1;
    timed_out = !done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; cfg_cols = 11'd5; cfg_rows = 11'd5; cfg_stride2 = 1'b0;
    s_valid = 1'b1; s_data = 8'hA5; win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (win_valid !== 1'b0) begin failures++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
    checks++; if (win_row !== 11'd0 || win_col !== 11'd0) begin failures++; $display("FAIL reset_coords got=%0d,%0d exp=0,0", win_row, win_col); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b err=%b exp=0", busy, frame_done, cfg_err); end
    checks++; if (s_ready !== 1'b0 || lb_valid_in !== 1'b0) begin failures++; $display("FAIL reset_ready got s_ready=%b lb_valid_in=%b exp=0", s_ready, lb_valid_in); end
    checks++; if (lb_din !== 8'hA5) begin failures++; $display("FAIL reset_din got=%h exp=a5", lb_din); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stride1;
    run_frame(5, 5, 1'b0, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL s1_timeout got=timeout exp=frame_done"); end
    checks++; if (n_acc !== 25) begin failures++; $display("FAIL s1_accepts got=%0d exp=25", n_acc); end
    checks++; if (n_win !== 9) begin failures++; $display("FAIL s1_windows got=%0d exp=9", n_win); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL s1_win%0d got=missing exp=(%0d,%0d)", i, i / 3, i % 3);
      end else if (win_r[i] !== i / 3 || win_c[i] !== i % 3 || win_p[i] !== exp_pix(5, 0, i / 3, i % 3)) begin
        failures++; $display("FAIL s1_win%0d got=(%0d,%0d)@pix%0d exp=(%0d,%0d)@pix%0d", i,
                             win_r[i], win_c[i], win_p[i], i / 3, i % 3, exp_pix(5, 0, i / 3, i % 3));
      end
    end
    checks++; if (n_done !== 1 || done_prev_pix !== 24) begin failures++; $display("FAIL s1_done got=%0d pulses after pix%0d exp=1 after pix24", n_done, done_prev_pix); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL s1_idle got busy=%b done=%b exp=0,0", busy, frame_done); end
    checks++; if (s_ready !== 1'b0 || lb_valid_in !== 1'b0) begin failures++; $display("FAIL s1_idle_ready got=%b,%b exp=0,0", s_ready, lb_valid_in); end
    checks++; if (win_row !== 11'd2 || win_col !== 11'd2 || win_valid !== 1'b0) begin failures++; $display("FAIL s1_hold got=(%0d,%0d) v=%b exp=(2,2) v=0", win_row, win_col, win_valid); end
    checks++; if (din_err !== 0 || cfg_err_seen !== 0) begin failures++; $display("FAIL s1_din_err got=%0d,%0d exp=0,0", din_err, cfg_err_seen); end
    s_valid = 1'b0;
  endtask

  task automatic test_stride2;
    run_frame(5, 5, 1'b1, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL s2_timeout got=timeout exp=frame_done"); end
    checks++; if (n_win !== 4) begin failures++; $display("FAIL s2_windows got=%0d exp=4", n_win); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL s2_win%0d got=missing exp=(%0d,%0d)", i, i / 2, i % 2);
      end else if (win_r[i] !== i / 2 || win_c[i] !== i % 2 || win_p[i] !== exp_pix(5, 1, i / 2, i % 2)) begin
        failures++; $display("FAIL s2_win%0d got=(%0d,%0d)@pix%0d exp=(%0d,%0d)@pix%0d", i,
                             win_r[i], win_c[i], win_p[i], i / 2, i % 2, exp_pix(5, 1, i / 2, i % 2));
      end
    end
    checks++; if (n_acc !== 25 || n_done !== 1 || done_prev_pix !== 24) begin failures++; $display("FAIL s2_frame got acc=%0d done=%0d@pix%0d exp acc=25 done=1@pix24", n_acc, n_done, done_prev_pix); end
    s_valid = 1'b0;
  endtask

  task automatic test_stall;
    run_frame(5, 5, 1'b0, 3, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL stall_timeout got=timeout exp=frame_done"); end
    checks++; if (stall_cycles !== 3 || stall_viol !== 0) begin failures++; $display("FAIL stall_block got cycles=%0d leaks=%0d exp=3,0", stall_cycles, stall_viol); end
    checks++; if (n_win !== 9 || n_acc !== 25) begin failures++; $display("FAIL stall_counts got win=%0d acc=%0d exp=9,25", n_win, n_acc); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL stall_win%0d got=missing exp=(%0d,%0d)", i, i / 3, i % 3);
      end else if (win_r[i] !== i / 3 || win_c[i] !== i % 3 || win_p[i] !== exp_pix(5, 0, i / 3, i % 3)) begin
        failures++; $display("FAIL stall_win%0d got=(%0d,%0d)@pix%0d exp=(%0d,%0d)@pix%0d", i,
                             win_r[i], win_c[i], win_p[i], i / 3, i % 3, exp_pix(5, 0, i / 3, i % 3));
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_cfg_err;
    cfg_cols = 11'd2; cfg_rows = 11'd5; cfg_stride2 = 1'b0; s_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfgerr_pulse got=%b exp=1", cfg_err); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0 || lb_valid_in !== 1'b0) begin failures++; $display("FAIL cfgerr_idle got busy=%b rdy=%b lbv=%b exp=0", busy, s_ready, lb_valid_in); end
    @(posedge clk); #1;
    checks++; if (cfg_err !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL cfgerr_single got err=%b rdy=%b exp=0,0", cfg_err, s_ready); end
    cfg_cols = 11'd483; cfg_rows = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cfgerr_wide got err=%b busy=%b exp=1,0", cfg_err, busy); end
    cfg_cols = 11'd5; cfg_rows = 11'd257; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL cfgerr_tall got err=%b busy=%b exp=1,0", cfg_err, busy); end
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    run_frame(482, 3, 1'b0, 0, -1);
    checks++; if (timed_out) begin failures++; $display("FAIL wide_timeout got=timeout exp=frame_done"); end
    checks++; if (n_win !== 480 || n_acc !== 1446) begin failures++; $display("FAIL wide_counts got win=%0d acc=%0d exp=480,1446", n_win, n_acc); end
    for (int i = 0; i < 480; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL wide_win%0d got=missing exp=(0,%0d)", i, i);
      end else if (win_r[i] !== 0 || win_c[i] !== i || win_p[i] !== exp_pix(482, 0, 0, i)) begin
        failures++; $display("FAIL wide_win%0d got=(%0d,%0d)@pix%0d exp=(0,%0d)@pix%0d", i,
                             win_r[i], win_c[i], win_p[i], i, exp_pix(482, 0, 0, i));
      end
    end
    checks++; if (n_done !== 1 || done_prev_pix !== 1445) begin failures++; $display("FAIL wide_done got=%0d@pix%0d exp=1@pix1445", n_done, done_prev_pix); end
    s_valid = 1'b0;
  endtask

  task automatic test_reset_abort;
    int cnt, cyc, ev;
    cfg_cols = 11'd5; cfg_rows = 11'd5; cfg_stride2 = 1'b0;
    s_valid = 1'b1; win_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 100) begin
      #1;
      if (lb_valid_in === 1'b1) cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (cnt !== 10 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre got acc=%0d busy=%b exp=10,1", cnt, busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || win_valid !== 1'b0 || frame_done !== 1'b0 || cfg_err !== 1'b0) begin failures++; $display("FAIL abort_flags got busy=%b wv=%b done=%b err=%b exp=0", busy, win_valid, frame_done, cfg_err); end
    checks++; if (s_ready !== 1'b0 || lb_valid_in !== 1'b0 || win_row !== 11'd0 || win_col !== 11'd0) begin failures++; $display("FAIL abort_outs got rdy=%b lbv=%b row=%0d col=%0d exp=0", s_ready, lb_valid_in, win_row, win_col); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ev = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (frame_done !== 1'b0 || busy !== 1'b0 || lb_valid_in !== 1'b0 || win_valid !== 1'b0) ev++;
    end
    checks++; if (ev !== 0) begin failures++; $display("FAIL abort_quiet got=%0d active cycles exp=0", ev); end
    run_frame(5, 5, 1'b0, 0, -1);
    checks++; if (timed_out || n_win !== 9 || n_acc !== 25 || n_done !== 1) begin failures++; $display("FAIL abort_rerun got win=%0d acc=%0d done=%0d exp=9,25,1", n_win, n_acc, n_done); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL abort_win%0d got=missing exp=(%0d,%0d)", i, i / 3, i % 3);
      end else if (win_r[i] !== i / 3 || win_c[i] !== i % 3 || win_p[i] !== exp_pix(5, 0, i / 3, i % 3)) begin
        failures++; $display("FAIL abort_win%0d got=(%0d,%0d)@pix%0d exp=(%0d,%0d)", i,
                             win_r[i], win_c[i], win_p[i], i / 3, i % 3);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_restart_ignored;
    run_frame(5, 5, 1'b0, 0, 15);
    checks++; if (timed_out) begin failures++; $display("FAIL restart_timeout got=timeout exp=frame_done"); end
    checks++; if (cfg_err_seen !== 0) begin failures++; $display("FAIL restart_cfgerr got=%0d exp=0", cfg_err_seen); end
    checks++; if (n_acc !== 25 || n_win !== 9 || done_prev_pix !== 24) begin failures++; $display("FAIL restart_counts got acc=%0d win=%0d done@pix%0d exp=25,9,24", n_acc, n_win, done_prev_pix); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= win_r.size()) begin
        failures++; $display("FAIL restart_win%0d got=missing exp=(%0d,%0d)", i, i / 3, i % 3);
      end else if (win_r[i] !== i / 3 || win_c[i] !== i % 3 || win_p[i] !== exp_pix(5, 0, i / 3, i % 3)) begin
        failures++; $display("FAIL restart_win%0d got=(%0d,%0d)@pix%0d exp=(%0d,%0d)", i,
                             win_r[i], win_c[i], win_p[i], i / 3, i % 3);
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stride1();
    test_stride2();
    test_stall();
    test_cfg_err();
    test_wide();
    test_reset_abort();
    test_restart_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
